frame_swap_scheduler: RTL and testbench
=======================================

// Module: frame_swap_scheduler
// PURPOSE
//  Sequences the double-buffered 1-bpp video banks. Requests each frame from the SPI
//  source and generates write addresses and strobes into the back bank. Flips the
//  display bank only at VGA frame boundaries, paced to the video frame rate.
//  Detects and reports underruns. Sits between the SPI receiver, both video banks and
//  the VGA position tracker.
// PARAMETERS
//  MEM_WIDTH      8     bank columns (screen width / 4)
//  MEM_HEIGHT     6     bank rows (screen height / 4)
//  REPEAT_FRAMES  2     VGA frames each video frame is shown (60Hz -> 30fps); >=1
//  TOTAL_FRAMES   6572  video frames in the clip; frame_idx width = $clog2(TOTAL_FRAMES+1)
// PORTS
//  CLK_40        in   1   40 MHz system clock
//  reset_n       in   1   asynchronous active-low reset
//  enable        in   1   level; high = play, low = abort to IDLE
//  frame_tick    in   1   1-cycle pulse at start of VGA vertical blank
//  fetch_req     out  1   request next frame stream from SPI
//  fetch_ack     in   1   SPI accepted request (1 cycle)
//  pix_valid     in   1   SPI pixel available
//  pix_data      in   1   SPI pixel value
//  pix_ready     out  1   scheduler accepts pixel (transfer = pix_valid & pix_ready)
//  wr_en         out  1   back-bank write strobe
//  wr_data       out  1   back-bank write data
//  wr_x          out  XW  write column, XW = $clog2(MEM_WIDTH)
//  wr_y          out  YW  write row,    YW = $clog2(MEM_HEIGHT)
//  disp_bank     out  1   bank shown on VGA; back bank = ~disp_bank
//  frame_idx     out  FW  video frames displayed so far
//  underrun      out  1   1-cycle pulse: swap due but back bank not full
//  done          out  1   level: clip finished
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; rep_cnt = REPEAT_FRAMES-1; primed = 0.
//  FSM: IDLE -> REQUEST (enable) -> LOAD (fetch_ack) -> READY (last pixel) -> REQUEST
//  on swap; DONE after final swap.
//  IDLE: enable=1 moves to REQUEST on the next cycle.
//  REQUEST: fetch_req=1, held until fetch_ack; the ack cycle moves to LOAD.
//  LOAD: pix_ready=1. Each transfer registers wr_en=1, wr_data, wr_x, wr_y one cycle
//  later (latency 1).
//  LOAD addressing: x increments, wraps at MEM_WIDTH-1 to 0 and increments y. At the
//  transfer to (MEM_WIDTH-1, MEM_HEIGHT-1): x,y clear, pix_ready drops the next cycle,
//  state goes to READY.
//  READY: pix_ready=0, fetch_req=0.
//  Pacing: rep_cnt increments on each frame_tick, saturating at REPEAT_FRAMES-1.
//  Swap fires at a frame_tick when rep_cnt==REPEAT_FRAMES-1 and either the state is
//  READY or the last pixel transfers in the same cycle.
//  Swap action, registered: disp_bank toggles, rep_cnt<=0, frame_idx++, primed<=1.
//  After swap, state goes to REQUEST, or to DONE if frame_idx reaches TOTAL_FRAMES.
//  Underrun: swap due but back bank incomplete and primed=1 -> underrun pulses for one
//  cycle, disp_bank holds (frame repeats), rep_cnt stays saturated, and the swap fires
//  on the first tick after READY. No underrun before the first swap.
//  DONE: done=1, fetch_req=0, pix_ready=0. Leaves only when enable is low (-> IDLE,
//  done cleared, frame_idx cleared).
//  enable low in any state: IDLE next cycle, fetch_req/pix_ready/wr_en 0, x,y cleared,
//  disp_bank and frame_idx held (frame_idx cleared only from DONE).
//  fetch_ack outside REQUEST, and pix_valid outside LOAD, are ignored.
//  Async reset mid-frame discards partial writes; no bank contents are cleared.
// CONFIGURATION
//  UNDERRUN_STATS_EN defined: adds output underrun_cnt [15:0]. Reset 0, increments on
//  each underrun pulse, saturates at 16'hFFFF, cleared on IDLE entry from DONE.
//  UNDERRUN_STATS_EN undefined: port and counter are absent; underrun pulse unchanged.
// STRUCTURE
//  video_pkg: sched_state_t enum {IDLE,REQUEST,LOAD,READY,DONE}; MEM_WIDTH/MEM_HEIGHT
//  defaults; the XW/YW width functions.
//  Sub-module wr_addr_counter: x/y counter with wrap, clear and last-pixel flag.
// TESTING (MEM_WIDTH=8, MEM_HEIGHT=6, REPEAT_FRAMES=2, TOTAL_FRAMES=3)
//  1 reset_n low mid-LOAD -> all outputs 0, state IDLE, rep_cnt=1 after release.
//  2 enable, fetch_ack at cycle 3, 48 pixels streamed -> 48 wr_en pulses, first (0,0),
//    last (7,5), pix_ready low after 48th. Next frame_tick -> disp_bank=1,
//    frame_idx=1, fetch_req=1 the cycle after.
//  3 Frame 2 loaded before the 1st tick after swap -> no swap on that tick; swap on
//    the 2nd tick (disp_bank=0).
//  4 Frame 2 pixels withheld past the 2nd tick -> underrun=1 for one cycle, disp_bank
//    unchanged. Finish the load -> swap on the next tick. underrun_cnt=1 when
//    UNDERRUN_STATS_EN is defined.
//  5 48th pixel transfer coincides with a due frame_tick -> swap that cycle, no underrun.
//  6 After the 3rd swap -> done=1, fetch_req stays 0. Drop enable -> IDLE, done=0,
//    frame_idx=0.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and sizing helpers for the double-buffered 1-bpp video bank scheduler.
// The bank geometry defaults here match the 32x24 screen downscaled by 4.
package video_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQUEST,
      LOAD,
      READY,
      DONE
   } sched_state_t;

   localparam int DEFAULT_MEM_WIDTH  = 8;
   localparam int DEFAULT_MEM_HEIGHT = 6;

   // Counters never collapse to zero bits, even for degenerate 1-wide dimensions.
   function automatic int min1_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int calc_xw(input int mem_width);
      return min1_clog2(mem_width);
   endfunction

   function automatic int calc_yw(input int mem_height);
      return min1_clog2(mem_height);
   endfunction

endpackage

// File: rtl/wr_addr_counter.sv
// Raster-order column/row counter for back-bank writes, with synchronous clear
// and a flag marking the final pixel of the bank.
module wr_addr_counter
   import video_pkg::*;
#(
   parameter int  MEM_WIDTH  = DEFAULT_MEM_WIDTH,
   parameter int  MEM_HEIGHT = DEFAULT_MEM_HEIGHT,
   localparam int XW         = calc_xw(MEM_WIDTH),
   localparam int YW         = calc_yw(MEM_HEIGHT)
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          advance,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          last
);

   localparam logic [XW-1:0] X_LAST = XW'(MEM_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(MEM_HEIGHT - 1);

   assign last = (x == X_LAST) && (y == Y_LAST);

   // The final pixel wraps both axes so the next frame starts at the origin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else if (clear || (advance && last)) begin
         x <= '0;
         y <= '0;
      end else if (advance) begin
         if (x == X_LAST) begin
            x <= '0;
            y <= y + YW'(1);
         end else begin
            x <= x + XW'(1);
         end
      end
   end

endmodule

// File: rtl/frame_swap_scheduler.sv
// Fetches each video frame from the SPI source into the back bank and flips banks on VGA
// frame ticks. Define UNDERRUN_STATS_EN to add the saturating underrun_cnt output.
module frame_swap_scheduler
   import video_pkg::*;
#(
   parameter int  MEM_WIDTH     = DEFAULT_MEM_WIDTH,
   parameter int  MEM_HEIGHT    = DEFAULT_MEM_HEIGHT,
   parameter int  REPEAT_FRAMES = 2,
   parameter int  TOTAL_FRAMES  = 6572,
   localparam int XW            = calc_xw(MEM_WIDTH),
   localparam int YW            = calc_yw(MEM_HEIGHT),
   localparam int FW            = $clog2(TOTAL_FRAMES + 1)
)(
   input  logic          CLK_40,
   input  logic          reset_n,
   input  logic          enable,
   input  logic          frame_tick,
   output logic          fetch_req,
   input  logic          fetch_ack,
   input  logic          pix_valid,
   input  logic          pix_data,
   output logic          pix_ready,
   output logic          wr_en,
   output logic          wr_data,
   output logic [XW-1:0] wr_x,
   output logic [YW-1:0] wr_y,
   output logic          disp_bank,
   output logic [FW-1:0] frame_idx,
   output logic          underrun,
   output logic          done
`ifdef UNDERRUN_STATS_EN
   ,
   output logic [15:0]   underrun_cnt
`endif
);

   localparam int            RW         = min1_clog2(REPEAT_FRAMES);
   localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_FRAMES - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(TOTAL_FRAMES - 1);

   sched_state_t  state;
   sched_state_t  next_state;
   logic [RW-1:0] rep_cnt;
   logic          primed;
   logic [XW-1:0] cur_x;
   logic [YW-1:0] cur_y;
   logic          cur_last;
   logic          transfer;
   logic          last_xfer;
   logic          tick_due;
   logic          back_full;
   logic          swap;
   logic          underrun_set;
   logic          at_last_frame;
   logic          leave_done;

   assign fetch_req     = enable && (state == REQUEST);
   assign pix_ready     = enable && (state == LOAD);
   assign done          = (state == DONE);
   assign transfer      = pix_valid && pix_ready;
   assign last_xfer     = transfer && cur_last;
   assign tick_due      = frame_tick && (rep_cnt == REP_LAST);
   assign back_full     = (state == READY) || last_xfer;
   assign swap          = enable && tick_due && back_full;
   assign at_last_frame = (frame_idx == FRAME_LAST);
   assign leave_done    = (state == DONE) && !enable;

   // A due tick with the back bank still filling repeats the current frame; suppressed until
   // the first swap so the initial fill never counts as an underrun.
   assign underrun_set  = enable && tick_due && !back_full && primed &&
                          ((state == REQUEST) || (state == LOAD));

   wr_addr_counter #(
      .MEM_WIDTH  (MEM_WIDTH),
      .MEM_HEIGHT (MEM_HEIGHT)
   ) u_addr (
      .clk     (CLK_40),
      .rst_n   (reset_n),
      .clear   (!enable),
      .advance (transfer),
      .x       (cur_x),
      .y       (cur_y),
      .last    (cur_last)
   );

   always_ff @(posedge CLK_40 or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      if (!enable) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    next_state = REQUEST;
            REQUEST: if (fetch_ack) next_state = LOAD;
            LOAD: begin
               if (last_xfer) begin
                  if (swap) next_state = at_last_frame ? DONE : REQUEST;
                  else      next_state = READY;
               end
            end
            READY:   if (swap) next_state = at_last_frame ? DONE : REQUEST;
            DONE:    next_state = DONE;
            default: next_state = IDLE;
         endcase
      end
   end

   // Pacing and bank flip: rep_cnt saturates so a late frame swaps on the first tick after it lands.
   always_ff @(posedge CLK_40 or negedge reset_n) begin
      if (!reset_n) begin
         rep_cnt   <= REP_LAST;
         disp_bank <= 1'b0;
         frame_idx <= '0;
         primed    <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         underrun <= underrun_set;
         if (swap) begin
            rep_cnt   <= '0;
            disp_bank <= ~disp_bank;
            frame_idx <= frame_idx + FW'(1);
            primed    <= 1'b1;
         end else begin
            if (frame_tick && (rep_cnt != REP_LAST)) rep_cnt <= rep_cnt + RW'(1);
            if (leave_done) begin
               frame_idx <= '0;
               primed    <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge CLK_40 or negedge reset_n) begin
      if (!reset_n) begin
         wr_en   <= 1'b0;
         wr_data <= 1'b0;
         wr_x    <= '0;
         wr_y    <= '0;
      end else begin
         wr_en <= transfer;
         if (transfer) begin
            wr_data <= pix_data;
            wr_x    <= cur_x;
            wr_y    <= cur_y;
         end
      end
   end

`ifdef UNDERRUN_STATS_EN
   always_ff @(posedge CLK_40 or negedge reset_n) begin
      if (!reset_n) begin
         underrun_cnt <= '0;
      end else if (leave_done) begin
         underrun_cnt <= '0;
      end else if (underrun_set && (underrun_cnt != 16'hFFFF)) begin
         underrun_cnt <= underrun_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_frame_swap_scheduler.sv
// Directed bench for frame_swap_scheduler: reset, frame load, pacing, underrun,
// coincident last-pixel swap and clip completion (8x6 banks, 2 repeats, 3 frames).
`timescale 1ns/1ps
module tb_frame_swap_scheduler;

   localparam int MEM_WIDTH     = 8;
   localparam int MEM_HEIGHT    = 6;
   localparam int REPEAT_FRAMES = 2;
   localparam int TOTAL_FRAMES  = 3;
   localparam int PIXELS        = MEM_WIDTH * MEM_HEIGHT;

   logic       clk        = 1'b0;
   logic       reset_n    = 1'b0;
   logic       enable     = 1'b0;
   logic       frame_tick = 1'b0;
   logic       fetch_ack  = 1'b0;
   logic       pix_valid  = 1'b0;
   logic       pix_data   = 1'b0;
   logic       fetch_req;
   logic       pix_ready;
   logic       wr_en;
   logic       wr_data;
   logic [2:0] wr_x;
   logic [2:0] wr_y;
   logic       disp_bank;
   logic [1:0] frame_idx;
   logic       underrun;
   logic       done;
`ifdef UNDERRUN_STATS_EN
   logic [15:0] underrun_cnt;
`endif

   int          checks          = 0;
   int          errors          = 0;
   int          wr_count        = 0;
   int          underrun_pulses = 0;
   int          first_x         = -1;
   int          first_y         = -1;
   int          last_x          = -1;
   int          last_y          = -1;
   logic [63:0] captured        = '0;

   always #5 clk = ~clk;

   frame_swap_scheduler #(
      .MEM_WIDTH     (MEM_WIDTH),
      .MEM_HEIGHT    (MEM_HEIGHT),
      .REPEAT_FRAMES (REPEAT_FRAMES),
      .TOTAL_FRAMES  (TOTAL_FRAMES)
   ) dut (
      .CLK_40     (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .frame_tick (frame_tick),
      .fetch_req  (fetch_req),
      .fetch_ack  (fetch_ack),
      .pix_valid  (pix_valid),
      .pix_data   (pix_data),
      .pix_ready  (pix_ready),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .wr_x       (wr_x),
      .wr_y       (wr_y),
      .disp_bank  (disp_bank),
      .frame_idx  (frame_idx),
      .underrun   (underrun),
      .done       (done)
`ifdef UNDERRUN_STATS_EN
      ,
      .underrun_cnt (underrun_cnt)
`endif
   );

   // Write-port monitor builds a picture of the back bank from the strobes it sees.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         if (wr_count == 0) begin
            first_x = int'(wr_x);
            first_y = int'(wr_y);
         end
         last_x = int'(wr_x);
         last_y = int'(wr_y);
         captured[int'(wr_y) * MEM_WIDTH + int'(wr_x)] = wr_data;
         wr_count++;
      end
      if (underrun === 1'b1) underrun_pulses++;
   end

   initial begin
      #1ms;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic pixel_bit(input int frame, input int i);
      return (((i + frame) % 3) == 0) || ((i % 7) == 2);
   endfunction

   function automatic logic [63:0] frame_image(input int frame);
      logic [63:0] img;
      img = '0;
      for (int i = 0; i < PIXELS; i++) img[i] = pixel_bit(frame, i);
      return img;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clearMonitor();
      wr_count        = 0;
      underrun_pulses = 0;
      first_x         = -1;
      first_y         = -1;
      last_x          = -1;
      last_y          = -1;
      captured        = '0;
   endtask

   task automatic pulseTick();
      frame_tick = 1'b1;
      nextCycle();
      frame_tick = 1'b0;
   endtask

   // Streams pixels first..first+n-1 of a frame, one per cycle, optionally ticking on the last.
   task automatic applyStimulus(input int first, input int n, input int frame, input bit tick_on_last);
      for (int i = 0; i < n; i++) begin
         pix_valid  = 1'b1;
         pix_data   = pixel_bit(frame, first + i);
         frame_tick = tick_on_last && (i == n - 1);
         nextCycle();
      end
      pix_valid  = 1'b0;
      pix_data   = 1'b0;
      frame_tick = 1'b0;
   endtask

   task automatic requestFrame(input string tag);
      int waited;
      waited = 0;
      while ((fetch_req !== 1'b1) && (waited < 8)) begin
         nextCycle();
         waited++;
      end
      checkOutput({tag, "_fetch_req"}, 64'(fetch_req), 64'(1));
      fetch_ack = 1'b1;
      nextCycle();
      fetch_ack = 1'b0;
      checkOutput({tag, "_load_pix_ready"}, 64'(pix_ready), 64'(1));
   endtask

   task automatic checkFrame(input string tag, input int frame);
      checkOutput({tag, "_wr_count"}, 64'(wr_count), 64'(PIXELS));
      checkOutput({tag, "_image"}, captured, frame_image(frame));
   endtask

   initial begin
      // Reset values
      repeat (3) nextCycle();
      checkOutput("rst_fetch_req", 64'(fetch_req), 64'(0));
      checkOutput("rst_pix_ready", 64'(pix_ready), 64'(0));
      checkOutput("rst_wr_en", 64'(wr_en), 64'(0));
      checkOutput("rst_disp_bank", 64'(disp_bank), 64'(0));
      checkOutput("rst_frame_idx", 64'(frame_idx), 64'(0));
      checkOutput("rst_underrun", 64'(underrun), 64'(0));
      checkOutput("rst_done", 64'(done), 64'(0));
      reset_n = 1'b1;
      nextCycle();

      // Test 1: async reset in the middle of a load
      enable = 1'b1;
      nextCycle();
      requestFrame("t1");
      applyStimulus(0, 10, 0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("t1_wr_en", 64'(wr_en), 64'(0));
      checkOutput("t1_pix_ready", 64'(pix_ready), 64'(0));
      checkOutput("t1_wr_xy", 64'({wr_x, wr_y}), 64'(0));
      checkOutput("t1_disp_bank", 64'(disp_bank), 64'(0));
      enable = 1'b0;
      nextCycle();
      reset_n = 1'b1;
      nextCycle();

      // Test 2: first frame, swap on the first tick
      clearMonitor();
      enable = 1'b1;
      #1;
      checkOutput("t2_idle_fetch_req", 64'(fetch_req), 64'(0));
      nextCycle();
      checkOutput("t2_req_fetch_req", 64'(fetch_req), 64'(1));
      checkOutput("t2_req_pix_ready", 64'(pix_ready), 64'(0));
      pix_valid = 1'b1;
      pix_data  = 1'b1;
      nextCycle();
      pix_valid = 1'b0;
      pix_data  = 1'b0;
      checkOutput("t2_req_held", 64'(fetch_req), 64'(1));
      requestFrame("t2");
      applyStimulus(0, PIXELS, 1, 1'b0);
      checkOutput("t2_pix_ready_drop", 64'(pix_ready), 64'(0));
      nextCycle();
      checkFrame("t2", 1);
      checkOutput("t2_first_xy", 64'({first_x[7:0], first_y[7:0]}), 64'(0));
      checkOutput("t2_last_xy", 64'({last_x[7:0], last_y[7:0]}), 64'({8'd7, 8'd5}));
      checkOutput("t2_bank_before", 64'(disp_bank), 64'(0));
      pulseTick();
      checkOutput("t2_disp_bank", 64'(disp_bank), 64'(1));
      checkOutput("t2_frame_idx", 64'(frame_idx), 64'(1));
      checkOutput("t2_next_fetch", 64'(fetch_req), 64'(1));
      checkOutput("t2_no_underrun", 64'(underrun_pulses), 64'(0));

      // Test 3: early load waits for the second tick
      clearMonitor();
      requestFrame("t3");
      applyStimulus(0, PIXELS, 2, 1'b0);
      nextCycle();
      checkFrame("t3", 2);
      pulseTick();
      checkOutput("t3_tick1_bank", 64'(disp_bank), 64'(1));
      checkOutput("t3_tick1_idx", 64'(frame_idx), 64'(1));
      nextCycle();
      pulseTick();
      checkOutput("t3_tick2_bank", 64'(disp_bank), 64'(0));
      checkOutput("t3_tick2_idx", 64'(frame_idx), 64'(2));
      checkOutput("t3_underrun_none", 64'(underrun_pulses), 64'(0));

      // Test 4: underrun, then the late frame swaps in and ends the clip
      clearMonitor();
      requestFrame("t4");
      applyStimulus(0, 20, 3, 1'b0);
      pulseTick();
      checkOutput("t4_tick1_underrun", 64'(underrun), 64'(0));
      pulseTick();
      checkOutput("t4_underrun", 64'(underrun), 64'(1));
      checkOutput("t4_bank_held", 64'(disp_bank), 64'(0));
      checkOutput("t4_idx_held", 64'(frame_idx), 64'(2));
      nextCycle();
      checkOutput("t4_underrun_pulse", 64'(underrun), 64'(0));
      applyStimulus(20, PIXELS - 20, 3, 1'b0);
      nextCycle();
      checkFrame("t4", 3);
      checkOutput("t4_underrun_count", 64'(underrun_pulses), 64'(1));
`ifdef UNDERRUN_STATS_EN
      checkOutput("t4_underrun_cnt", 64'(underrun_cnt), 64'(1));
`endif
      pulseTick();
      checkOutput("t4_swap_bank", 64'(disp_bank), 64'(1));
      checkOutput("t4_swap_idx", 64'(frame_idx), 64'(3));
      checkOutput("t4_done", 64'(done), 64'(1));

      // Test 6: clip finished, then abort back to idle
      repeat (3) nextCycle();
      checkOutput("t6_done_level", 64'(done), 64'(1));
      checkOutput("t6_fetch_req", 64'(fetch_req), 64'(0));
      checkOutput("t6_pix_ready", 64'(pix_ready), 64'(0));
      pulseTick();
      checkOutput("t6_tick_idx", 64'(frame_idx), 64'(3));
      checkOutput("t6_tick_bank", 64'(disp_bank), 64'(1));
      enable = 1'b0;
      nextCycle();
      checkOutput("t6_idle_done", 64'(done), 64'(0));
      checkOutput("t6_idle_idx", 64'(frame_idx), 64'(0));
      checkOutput("t6_idle_bank", 64'(disp_bank), 64'(1));
`ifdef UNDERRUN_STATS_EN
      checkOutput("t6_underrun_cnt", 64'(underrun_cnt), 64'(0));
`endif

      // Test 5: last pixel coincides with a due tick
      clearMonitor();
      enable = 1'b1;
      nextCycle();
      requestFrame("t5");
      applyStimulus(0, PIXELS, 4, 1'b1);
      checkOutput("t5_bank", 64'(disp_bank), 64'(0));
      checkOutput("t5_idx", 64'(frame_idx), 64'(1));
      checkOutput("t5_fetch_req", 64'(fetch_req), 64'(1));
      checkOutput("t5_underrun", 64'(underrun), 64'(0));
      nextCycle();
      checkFrame("t5", 4);
      checkOutput("t5_underrun_count", 64'(underrun_pulses), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
